// File: rtl/ula_op_sequencer.sv
// Sequences one ULA opcode: pops operands from the data stack, loads the ULA operand registers, then writes the result back.
// Latency from accept: binary op EXEC 5 cycles later, NOT 3 cycles, error DONE 1 cycle.
// Backpressure: OP_READY is high only in IDLE with no TOS_LOAD; a waiting OP_VALID is held until then.
//
// Ports: OP_VALID/OP_CODE/OP_READY opcode handshake; TOS_LOAD/TOS_LOAD_VALUE external TOS overwrite;
//   STACK_ADDR/STACK_DATA_IN/STACK_WRITE/STACK_DATA_OUT data-stack access (1-cycle read latency);
//   ULA_RESULT_IN, OPERAND_OUT, CTRL_REG_OP1/OP2/OVERFLOW, CTRL_STACK_COMP, SEL_ULA drive the ULA block;
//   TOS_OUT entry count, DONE completion pulse, ERR_UNDERFLOW/ERR_ILLEGAL sticky errors.
// Optional: define ULA_SEQ_STATS_EN to add OP_COUNT (saturating completion count) and CNT_CLR.
module ula_op_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  OP_VALID,
    input  logic [3:0]            OP_CODE,
    output logic                  OP_READY,
    input  logic                  TOS_LOAD,
    input  logic [ADDR_WIDTH-1:0] TOS_LOAD_VALUE,
    output logic [ADDR_WIDTH-1:0] STACK_ADDR,
    input  logic [DATA_WIDTH-1:0] STACK_DATA_IN,
    output logic                  STACK_WRITE,
    output logic [DATA_WIDTH-1:0] STACK_DATA_OUT,
    input  logic [DATA_WIDTH-1:0] ULA_RESULT_IN,
    output logic [DATA_WIDTH-1:0] OPERAND_OUT,
    output logic                  CTRL_REG_OP1,
    output logic                  CTRL_REG_OP2,
    output logic                  CTRL_REG_OVERFLOW,
    output logic                  CTRL_STACK_COMP,
    output logic [3:0]            SEL_ULA,
    output logic [ADDR_WIDTH-1:0] TOS_OUT,
    output logic                  DONE,
    output logic                  ERR_UNDERFLOW,
    output logic                  ERR_ILLEGAL
`ifdef ULA_SEQ_STATS_EN
    ,
    output logic [15:0]           OP_COUNT,
    input  logic                  CNT_CLR
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD1  = 3'd1;
    localparam logic [2:0] S_LD1  = 3'd2;
    localparam logic [2:0] S_RD2  = 3'd3;
    localparam logic [2:0] S_LD2  = 3'd4;
    localparam logic [2:0] S_EXEC = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic [2:0]            r_state;
    logic [3:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_tos;
    logic                  r_err_uf;
    logic                  r_err_il;

    logic                  w_in_illegal;
    logic                  w_in_unary;
    logic                  w_in_underflow;
    logic                  w_is_not;
    logic                  w_is_cmp;
    logic [ADDR_WIDTH-1:0] w_tos_m1;
    logic [ADDR_WIDTH-1:0] w_tos_m2;

    assign w_in_illegal   = (OP_CODE == 4'hF);
    assign w_in_unary     = (OP_CODE == 4'h8);
    // NOT needs one entry, every other legal op needs two
    assign w_in_underflow = w_in_unary ? (r_tos == '0) : (r_tos < ADDR_WIDTH'(2));
    assign w_is_not       = (r_op == 4'h8);
    assign w_is_cmp       = (r_op >= 4'h9) && (r_op <= 4'hE);
    assign w_tos_m1       = r_tos - ADDR_WIDTH'(1);
    assign w_tos_m2       = r_tos - ADDR_WIDTH'(2);

    assign OP_READY      = (r_state == S_IDLE) && !TOS_LOAD;
    assign TOS_OUT       = r_tos;
    assign ERR_UNDERFLOW = r_err_uf;
    assign ERR_ILLEGAL   = r_err_il;
    assign SEL_ULA       = (r_state == S_IDLE) ? 4'h0 : r_op;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= 4'h0;
            r_tos    <= '0;
            r_err_uf <= 1'b0;
            r_err_il <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (TOS_LOAD) begin
                        r_tos <= TOS_LOAD_VALUE;
                    end else if (OP_VALID) begin
                        r_op <= OP_CODE;
                        if (w_in_illegal || w_in_underflow) begin
                            r_state <= S_ERR;
                        end else begin
                            r_state <= S_RD1;
                        end
                    end
                end
                S_RD1:  r_state <= S_LD1;
                S_LD1:  r_state <= w_is_not ? S_EXEC : S_RD2;
                S_RD2:  r_state <= S_LD2;
                S_LD2:  r_state <= S_EXEC;
                S_EXEC: begin
                    // binary ops consume two entries and leave one
                    if (!w_is_not) begin
                        r_tos <= w_tos_m1;
                    end
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    if (r_op == 4'hF) begin
                        r_err_il <= 1'b1;
                    end else begin
                        r_err_uf <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        STACK_ADDR        = '0;
        STACK_WRITE       = 1'b0;
        STACK_DATA_OUT    = '0;
        OPERAND_OUT       = '0;
        CTRL_REG_OP1      = 1'b0;
        CTRL_REG_OP2      = 1'b0;
        CTRL_REG_OVERFLOW = 1'b0;
        CTRL_STACK_COMP   = 1'b0;
        DONE              = 1'b0;
        case (r_state)
            S_RD1: STACK_ADDR = w_tos_m1;
            S_LD1: begin
                STACK_ADDR   = w_tos_m1;
                OPERAND_OUT  = STACK_DATA_IN;
                CTRL_REG_OP1 = 1'b1;
            end
            S_RD2: STACK_ADDR = w_tos_m2;
            S_LD2: begin
                STACK_ADDR   = w_tos_m2;
                OPERAND_OUT  = STACK_DATA_IN;
                CTRL_REG_OP2 = 1'b1;
            end
            S_EXEC: begin
                DONE = 1'b1;
                if (w_is_not) begin
                    STACK_ADDR     = w_tos_m1;
                    STACK_WRITE    = 1'b1;
                    STACK_DATA_OUT = ULA_RESULT_IN;
                end else if (w_is_cmp) begin
                    // compare result goes to the 1-bit stack; data slot left stale
                    STACK_ADDR      = w_tos_m2;
                    CTRL_STACK_COMP = 1'b1;
                end else begin
                    STACK_ADDR        = w_tos_m2;
                    STACK_WRITE       = 1'b1;
                    STACK_DATA_OUT    = ULA_RESULT_IN;
                    CTRL_REG_OVERFLOW = (r_op <= 4'h4);
                end
            end
            S_ERR: DONE = 1'b1;
            default: ;
        endcase
    end

`ifdef ULA_SEQ_STATS_EN
    logic [15:0] r_op_count;
    assign OP_COUNT = r_op_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_count <= 16'h0;
        end else if (CNT_CLR) begin
            r_op_count <= 16'h0;
        end else if ((r_state == S_EXEC) && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'h1;
        end
    end
`endif

endmodule

// File: tb/tb_ula_op_sequencer.sv
module tb_ula_op_sequencer;

    localparam int DW = 8;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          OP_VALID;
    logic [3:0]    OP_CODE;
    logic          OP_READY;
    logic          TOS_LOAD;
    logic [AW-1:0] TOS_LOAD_VALUE;
    logic [AW-1:0] STACK_ADDR;
    logic [DW-1:0] STACK_DATA_IN;
    logic          STACK_WRITE;
    logic [DW-1:0] STACK_DATA_OUT;
    logic [DW-1:0] ULA_RESULT_IN;
    logic [DW-1:0] OPERAND_OUT;
    logic          CTRL_REG_OP1;
    logic          CTRL_REG_OP2;
    logic          CTRL_REG_OVERFLOW;
    logic          CTRL_STACK_COMP;
    logic [3:0]    SEL_ULA;
    logic [AW-1:0] TOS_OUT;
    logic          DONE;
    logic          ERR_UNDERFLOW;
    logic          ERR_ILLEGAL;

    always #5 clk = ~clk;

    ula_op_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .OP_VALID(OP_VALID), .OP_CODE(OP_CODE), .OP_READY(OP_READY),
        .TOS_LOAD(TOS_LOAD), .TOS_LOAD_VALUE(TOS_LOAD_VALUE), .STACK_ADDR(STACK_ADDR),
        .STACK_DATA_IN(STACK_DATA_IN), .STACK_WRITE(STACK_WRITE), .STACK_DATA_OUT(STACK_DATA_OUT),
        .ULA_RESULT_IN(ULA_RESULT_IN), .OPERAND_OUT(OPERAND_OUT), .CTRL_REG_OP1(CTRL_REG_OP1),
        .CTRL_REG_OP2(CTRL_REG_OP2), .CTRL_REG_OVERFLOW(CTRL_REG_OVERFLOW),
        .CTRL_STACK_COMP(CTRL_STACK_COMP), .SEL_ULA(SEL_ULA), .TOS_OUT(TOS_OUT), .DONE(DONE),
        .ERR_UNDERFLOW(ERR_UNDERFLOW), .ERR_ILLEGAL(ERR_ILLEGAL)
    );

    // data stack with 1-cycle read latency, plus a bench preload port
    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] rd_q;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (STACK_WRITE) mem[STACK_ADDR] <= STACK_DATA_OUT;
        rd_q <= mem[STACK_ADDR];
    end
    assign STACK_DATA_IN = rd_q;

    // ULA model: operand registers plus a small op table
    logic [DW-1:0] u1, u2;
    always @(posedge clk) begin
        if (CTRL_REG_OP1) u1 <= OPERAND_OUT;
        if (CTRL_REG_OP2) u2 <= OPERAND_OUT;
    end
    always_comb begin
        case (SEL_ULA)
            4'h0:    ULA_RESULT_IN = u2 + u1;
            4'h1:    ULA_RESULT_IN = u2 - u1;
            4'h8:    ULA_RESULT_IN = ~u1;
            default: ULA_RESULT_IN = u2 ^ u1;
        endcase
    end

    // strobe monitor (cumulative, sampled at the edge ending each cycle)
    int            n_op1 = 0, n_op2 = 0, n_wr = 0;
    logic [DW-1:0] last_op1 = '0, last_op2 = '0;
    always @(posedge clk) begin
        if (CTRL_REG_OP1) begin n_op1 <= n_op1 + 1; last_op1 <= OPERAND_OUT; end
        if (CTRL_REG_OP2) begin n_op2 <= n_op2 + 1; last_op2 <= OPERAND_OUT; end
        if (STACK_WRITE)  n_wr <= n_wr + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit            rst;
        logic [AW-1:0] tos;
        logic [DW-1:0] v_top;
        logic [DW-1:0] v_next;
        logic [3:0]    op;
        int            lat;
        bit            wr;
        bit            comp;
        bit            ovf;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [AW-1:0] ntos;
        int            n1;
        int            n2;
        bit            euf;
        bit            eil;
    } vec_t;

    vec_t vecs[12];
    vec_t sb[$];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; OP_VALID = 1'b0; TOS_LOAD = 1'b0; OP_CODE = 4'h0; TOS_LOAD_VALUE = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_tos(input logic [AW-1:0] v);
        @(negedge clk);
        TOS_LOAD = 1'b1; TOS_LOAD_VALUE = v;
        @(negedge clk);
        TOS_LOAD = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // drive an opcode at the next negedge, return cycles from accept edge to DONE
    task automatic issue(input logic [3:0] op, output int lat);
        @(negedge clk);
        OP_VALID = 1'b1; OP_CODE = op;
        #1 chk("op_ready_idle", OP_READY, 1);
        @(posedge clk);
        @(negedge clk);
        OP_VALID = 1'b0;
        lat = 1;
        while (!DONE && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   lat, b1, b2, bw;
        vec_t e;
        if (v.rst) do_reset();
        load_tos(v.tos);
        if (v.tos >= 1) preload(v.tos - 12'd1, v.v_top);
        if (v.tos >= 2) preload(v.tos - 12'd2, v.v_next);
        b1 = n_op1; b2 = n_op2; bw = n_wr;
        sb.push_back(v);
        issue(v.op, lat);
        e = sb.pop_front();
        chk($sformatf("v%0d_latency", idx), lat, e.lat);
        chk($sformatf("v%0d_write", idx), STACK_WRITE, e.wr);
        chk($sformatf("v%0d_comp", idx), CTRL_STACK_COMP, e.comp);
        chk($sformatf("v%0d_ovf", idx), CTRL_REG_OVERFLOW, e.ovf);
        if (e.wr || e.comp) chk($sformatf("v%0d_addr", idx), STACK_ADDR, e.addr);
        if (e.wr) chk($sformatf("v%0d_data", idx), STACK_DATA_OUT, e.data);
        @(negedge clk);
        chk($sformatf("v%0d_ready_after", idx), OP_READY, 1);
        chk($sformatf("v%0d_tos", idx), TOS_OUT, e.ntos);
        chk($sformatf("v%0d_err_uf", idx), ERR_UNDERFLOW, e.euf);
        chk($sformatf("v%0d_err_il", idx), ERR_ILLEGAL, e.eil);
        chk($sformatf("v%0d_n_op1", idx), n_op1 - b1, e.n1);
        chk($sformatf("v%0d_n_op2", idx), n_op2 - b2, e.n2);
        chk($sformatf("v%0d_n_wr", idx), n_wr - bw, e.wr ? 1 : 0);
        if (e.n1 > 0) chk($sformatf("v%0d_op1_val", idx), last_op1, e.v_top);
        if (e.n2 > 0) chk($sformatf("v%0d_op2_val", idx), last_op2, e.v_next);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, bw;
        //          rst tos     top    next   op    lat wr cp ov addr    data   ntos    n1 n2 euf eil
        vecs[0]  = '{1, 12'd3,  8'h07, 8'h05, 4'h0, 5, 1, 0, 1, 12'd1,  8'h0C, 12'd2,  1, 1, 0, 0};
        vecs[1]  = '{0, 12'd2,  8'h04, 8'h09, 4'hB, 5, 0, 1, 0, 12'd0,  8'h00, 12'd1,  1, 1, 0, 0};
        vecs[2]  = '{0, 12'd1,  8'hA5, 8'h00, 4'h8, 3, 1, 0, 0, 12'd0,  8'h5A, 12'd1,  1, 0, 0, 0};
        vecs[3]  = '{0, 12'd1,  8'h00, 8'h00, 4'h1, 1, 0, 0, 0, 12'd0,  8'h00, 12'd1,  0, 0, 1, 0};
        vecs[4]  = '{0, 12'd1,  8'h00, 8'h00, 4'hF, 1, 0, 0, 0, 12'd0,  8'h00, 12'd1,  0, 0, 1, 1};
        vecs[5]  = '{1, 12'd4,  8'h03, 8'h10, 4'h1, 5, 1, 0, 1, 12'd2,  8'h0D, 12'd3,  1, 1, 0, 0};
        vecs[6]  = '{0, 12'd2,  8'h3C, 8'hF0, 4'h5, 5, 1, 0, 0, 12'd0,  8'hCC, 12'd1,  1, 1, 0, 0};
        vecs[7]  = '{1, 12'd0,  8'h00, 8'h00, 4'h8, 1, 0, 0, 0, 12'd0,  8'h00, 12'd0,  0, 0, 1, 0};
        vecs[8]  = '{1, 12'hFFF,8'h81, 8'h18, 4'h4, 5, 1, 0, 1, 12'hFFD,8'h99, 12'hFFE,1, 1, 0, 0};
        vecs[9]  = '{0, 12'd2,  8'h00, 8'h55, 4'h8, 3, 1, 0, 0, 12'd1,  8'hFF, 12'd2,  1, 0, 0, 0};
        vecs[10] = '{1, 12'd0,  8'h00, 8'h00, 4'hF, 1, 0, 0, 0, 12'd0,  8'h00, 12'd0,  0, 0, 0, 1};
        vecs[11] = '{0, 12'd1,  8'h00, 8'h00, 4'hE, 1, 0, 0, 0, 12'd0,  8'h00, 12'd1,  0, 0, 1, 1};

        rst_n = 1'b0; OP_VALID = 1'b0; OP_CODE = 4'h0; TOS_LOAD = 1'b0; TOS_LOAD_VALUE = '0;
        do_reset();
        #1;
        chk("rst_tos", TOS_OUT, 0);
        chk("rst_ready", OP_READY, 1);
        chk("rst_done", DONE, 0);
        chk("rst_errs", {ERR_UNDERFLOW, ERR_ILLEGAL}, 0);
        chk("rst_strobes", {CTRL_REG_OP1, CTRL_REG_OP2, CTRL_REG_OVERFLOW, CTRL_STACK_COMP, STACK_WRITE}, 0);
        chk("rst_addr_sel", {STACK_ADDR, SEL_ULA, OPERAND_OUT}, 0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // reset during LD2 abandons the op with no write
        do_reset();
        load_tos(12'd3);
        preload(12'd2, 8'h44);
        preload(12'd1, 8'h11);
        bw = n_wr;
        @(negedge clk);
        OP_VALID = 1'b1; OP_CODE = 4'h0;
        @(posedge clk);
        @(negedge clk);
        OP_VALID = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_in_ld2", CTRL_REG_OP2, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", OP_READY, 1);
        chk("midrst_tos", TOS_OUT, 0);
        chk("midrst_sel", SEL_ULA, 0);
        chk("midrst_done", DONE, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_write", n_wr - bw, 0);

        // OP_VALID and TOS_LOAD together: load wins, op accepted next cycle with new TOS
        preload(12'd3, 8'h11);
        preload(12'd2, 8'h22);
        @(negedge clk);
        OP_VALID = 1'b1; OP_CODE = 4'h0; TOS_LOAD = 1'b1; TOS_LOAD_VALUE = 12'd4;
        #1 chk("conc_ready_low", OP_READY, 0);
        @(negedge clk);
        TOS_LOAD = 1'b0;
        chk("conc_tos_loaded", TOS_OUT, 4);
        #1 chk("conc_ready_high", OP_READY, 1);
        @(posedge clk);
        @(negedge clk);
        OP_VALID = 1'b0;
        lat = 1;
        while (!DONE && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("conc_latency", lat, 5);
        chk("conc_addr", STACK_ADDR, 2);
        chk("conc_data", STACK_DATA_OUT, 8'h33);
        @(negedge clk);
        chk("conc_tos_after", TOS_OUT, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
